// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: hands the command/address bus to the init, refresh, write or read stage.
// Optional macro SDRAM_ARB_RR_EN: alternate write/read on a tie instead of fixed write-first priority.
module sdram_arbit (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        aref_req,
   input  logic        aref_end,
   input  logic [3:0]  aref_cmd,
   input  logic        write_req,
   input  logic        write_end,
   input  logic [3:0]  write_cmd,
   input  logic [11:0] write_addr,
   input  logic [1:0]  write_bank,
   input  logic        read_req,
   input  logic        read_end,
   input  logic [3:0]  read_cmd,
   input  logic [11:0] read_addr,
   input  logic [1:0]  read_bank,
   output logic        aref_en,
   output logic        write_en,
   output logic        read_en,
   output logic        refresh_req,
   output logic [3:0]  sdram_cmd,
   output logic [1:0]  sdram_ba,
   output logic [11:0] sdram_addr
);

   localparam logic [3:0] CMD_NOP = 4'b0111;

   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_AREF  = 5'b00100,
      S_WRITE = 5'b01000,
      S_READ  = 5'b10000
   } state_t;

   state_t state;
   state_t next_state;
   logic   refresh_q;
   logic   pick_write;

`ifdef SDRAM_ARB_RR_EN
   logic   last_write;

   // Remember which of write/read was granted last (0 = read) for the tie-break
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_write <= 1'b0;
      end else if (state == S_ARBIT && next_state == S_WRITE) begin
         last_write <= 1'b1;
      end else if (state == S_ARBIT && next_state == S_READ) begin
         last_write <= 1'b0;
      end else begin
         last_write <= last_write;
      end
   end

   assign pick_write = ~last_write;
`else
   assign pick_write = 1'b1;
`endif

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_INIT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a stage that re-requests while refresh is due has already yielded
   always_comb begin
      next_state = state;
      case (state)
         S_INIT: begin
            if (init_end) begin
               next_state = S_ARBIT;
            end else begin
               next_state = S_INIT;
            end
         end
         S_ARBIT: begin
            if (aref_req) begin
               next_state = S_AREF;
            end else if (write_req && read_req) begin
               next_state = pick_write ? S_WRITE : S_READ;
            end else if (write_req) begin
               next_state = S_WRITE;
            end else if (read_req) begin
               next_state = S_READ;
            end else begin
               next_state = S_ARBIT;
            end
         end
         S_AREF: begin
            if (aref_end) begin
               next_state = S_ARBIT;
            end else begin
               next_state = S_AREF;
            end
         end
         S_WRITE: begin
            if (write_end || (aref_req && write_req)) begin
               next_state = S_ARBIT;
            end else begin
               next_state = S_WRITE;
            end
         end
         S_READ: begin
            if (read_end || (aref_req && read_req)) begin
               next_state = S_ARBIT;
            end else begin
               next_state = S_READ;
            end
         end
         default: begin
            next_state = S_ARBIT;
         end
      endcase
   end

   // One-cycle delayed copy of the refresh request for the write/read stages
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         refresh_q <= 1'b0;
      end else begin
         refresh_q <= aref_req;
      end
   end

   assign refresh_req = refresh_q & (state != S_INIT);
   assign aref_en     = (state == S_AREF);
   assign write_en    = (state == S_WRITE);
   assign read_en     = (state == S_READ);

   // Bus mux; reset forces NOP without waiting for the state register to settle
   always_comb begin
      sdram_cmd  = CMD_NOP;
      sdram_ba   = 2'b00;
      sdram_addr = 12'h000;
      if (!sys_rst_n) begin
         sdram_cmd  = CMD_NOP;
         sdram_ba   = 2'b00;
         sdram_addr = 12'h000;
      end else begin
         case (state)
            S_INIT: begin
               sdram_cmd  = init_cmd;
               sdram_addr = init_addr;
            end
            S_AREF: begin
               sdram_cmd  = aref_cmd;
            end
            S_WRITE: begin
               sdram_cmd  = write_cmd;
               sdram_addr = write_addr;
               sdram_ba   = write_bank;
            end
            S_READ: begin
               sdram_cmd  = read_cmd;
               sdram_addr = read_addr;
               sdram_ba   = read_bank;
            end
            default: begin
               sdram_cmd  = CMD_NOP;
            end
         endcase
      end
   end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have port sys_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port sys_rst_n, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have port init_end, input, 1, power-up initialisation sequence complete (level).
REQ-004 SHALL have port init_cmd, input, 4, init-stage command {CS_N,RAS_N,CAS_N,WE_N}.
REQ-005 SHALL have port init_addr, input, 12, init-stage address (mode register value).
REQ-006 SHALL have port aref_req, input, 1, auto-refresh due (level, held until served).
REQ-007 SHALL have port aref_end, input, 1, refresh stage finished (1-cycle pulse).
REQ-008 SHALL have port aref_cmd, input, 4, refresh-stage command.
REQ-009 SHALL have port write_req, input, 1, write stage requests the bus (level).
REQ-010 SHALL have port write_end, input, 1, write stage finished all data (pulse).
REQ-011 SHALL have port write_cmd, input, 4, write-stage command.
REQ-012 SHALL have port write_addr, input, 12, write-stage address.
REQ-013 SHALL have port write_bank, input, 2, write-stage bank address.
REQ-014 SHALL have port read_req, input, 1, read stage requests the bus (level).
REQ-015 SHALL have port read_end, input, 1, read stage finished (pulse).
REQ-016 SHALL have port read_cmd, input, 4, read-stage command.
REQ-017 SHALL have port read_addr, input, 12, read-stage address.
REQ-018 SHALL have port read_bank, input, 2, read-stage bank address.
REQ-019 SHALL have port aref_en, output, 1, grant to refresh stage (level).
REQ-020 SHALL have port write_en, output, 1, grant to write stage (level).
REQ-021 SHALL have port read_en, output, 1, grant to read stage (level).
REQ-022 SHALL have port refresh_req, output, 1, refresh pending, routed to write/read stages so they yield at burst end.
REQ-023 SHALL have port sdram_cmd, output, 4, command to SDRAM pins.
REQ-024 SHALL have port sdram_ba, output, 2, bank address to SDRAM.
REQ-025 SHALL have port sdram_addr, output, 12, address to SDRAM.

Function
REQ-026 SHALL implement a one-hot 5-bit FSM: S_INIT=00001, S_ARBIT=00010, S_AREF=00100, S_WRITE=01000, S_READ=10000; illegal encodings go to S_ARBIT next cycle.
REQ-027 S_INIT -> S_ARBIT when init_end=1; init_end ignored in all other states.
REQ-028 In S_ARBIT, priority: aref_req -> S_AREF; else write_req -> S_WRITE; else read_req -> S_READ; else stay; decision takes exactly one cycle in S_ARBIT.
REQ-029 S_AREF -> S_ARBIT on aref_end; S_READ -> S_ARBIT on read_end.
REQ-030 S_WRITE -> S_ARBIT on write_end, or when aref_req=1 and write_req=1 (stage has yielded and re-requests); same exit rule applies to S_READ with read_req.
REQ-031 aref_en/write_en/read_en SHALL be combinational decodes of state==S_AREF/S_WRITE/S_READ; at most one high in any cycle.
REQ-032 refresh_req SHALL equal aref_req registered by one cycle, forced 0 while state==S_INIT.
REQ-033 Bus mux, combinational on state: S_INIT -> init_cmd/init_addr/ba 00; S_AREF -> aref_cmd/addr 0/ba 00; S_WRITE -> write_cmd/write_addr/write_bank; S_READ -> read_cmd/read_addr/read_bank; S_ARBIT -> NOP 4'b0111/addr 0/ba 00.
REQ-034 Simultaneous end pulse and new request: exit to S_ARBIT first; new grant no earlier than two cycles after the end pulse.

Reset
REQ-035 While sys_rst_n=0: state=S_INIT, all *_en=0, refresh_req=0, sdram_cmd=4'b0111, sdram_addr=0, sdram_ba=0; mid-operation reset aborts any grant immediately.

Configuration
REQ-036 Macro SDRAM_ARB_RR_EN defined: a last-served flag (reset 0 = read) SHALL give the write/read tie to the stage not last served (aref still highest); undefined: fixed priority aref>write>read, flag not built.

Verification
REQ-037 Reset, init_end=1 at cycle 10 -> state S_ARBIT at cycle 11, sdram_cmd 0111 throughout.
REQ-038 In S_ARBIT, aref_req=write_req=1 same cycle -> aref_en=1 next cycle, write_en=0; after aref_end, write_en=1 two cycles later.
REQ-039 In S_WRITE, write_cmd=0100, write_addr=12'h1F0, write_bank=2'b01 -> sdram_cmd=0100, sdram_addr=12'h1F0, sdram_ba=01 same cycle.
REQ-040 In S_WRITE, aref_req rises, write_req re-asserts 4 cycles later -> S_ARBIT then aref_en=1; refresh_req high one cycle after aref_req.
REQ-041 write_req=read_req=1 continuously, end pulses after each grant -> without macro write always granted; with SDRAM_ARB_RR_EN grants alternate W,R,W,R.
REQ-042 Assert sys_rst_n=0 while in S_READ -> read_en=0 and sdram_cmd=0111 in the same cycle, state S_INIT.
